// File: rtl/unipolar_rz_multi.sv
// Multi-channel unipolar return-to-zero driver for addressable LED strings.
// One shared bit-timing engine shifts CHANNELS words out in lock-step, then holds a latch low period.
module unipolar_rz_multi #(
  parameter int  CHANNELS       = 4,
  parameter int  DATA_WIDTH     = 24,
  parameter real CLOCK_RATE     = 100e6,
  parameter real PERIOD_TIME    = 1.2e-6,
  parameter real ZERO_HIGH_TIME = 0.3e-6,
  parameter real ONE_HIGH_TIME  = 0.6e-6,
  parameter real RESET_TIME     = 80e-6,
  parameter bit  MSB_FIRST      = 1'b0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data,
  input  logic [CHANNELS-1:0]            channel_mask,
  input  logic                           enable,
  output logic                           ready,
  output logic [CHANNELS-1:0]            line
);
  localparam int PERIOD_CYCLES    = int'(CLOCK_RATE * PERIOD_TIME);
  localparam int ZERO_HIGH_CYCLES = int'(CLOCK_RATE * ZERO_HIGH_TIME);
  localparam int ONE_HIGH_CYCLES  = int'(CLOCK_RATE * ONE_HIGH_TIME);
  localparam int RESET_CYCLES     = int'(CLOCK_RATE * RESET_TIME);

  localparam int PHASE_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int INDEX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int LATCH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD_CYCLES - 1);
  localparam logic [PHASE_W-1:0] ZERO_HIGH  = PHASE_W'(ZERO_HIGH_CYCLES);
  localparam logic [PHASE_W-1:0] ONE_HIGH   = PHASE_W'(ONE_HIGH_CYCLES);
  localparam logic [INDEX_W-1:0] INDEX_LAST = INDEX_W'(DATA_WIDTH - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(RESET_CYCLES - 1);

  generate
    if (!(ZERO_HIGH_CYCLES > 0 && ZERO_HIGH_CYCLES < ONE_HIGH_CYCLES &&
          ONE_HIGH_CYCLES < PERIOD_CYCLES && RESET_CYCLES >= 1)) begin : g_bad_timing
      $fatal(1, "unipolar_rz_multi: bit timing does not fit the clock rate");
    end
  endgenerate

  typedef enum logic [1:0] {S_LATCH, S_IDLE, S_BIT} state_t;

  state_t                          r_state;
  logic [LATCH_W-1:0]              r_latch_cnt;
  logic [PHASE_W-1:0]              r_phase;
  logic [INDEX_W-1:0]              r_bit_idx;
  logic [CHANNELS*DATA_WIDTH-1:0]  r_word;
  logic [CHANNELS-1:0]             r_mask;
  logic [CHANNELS-1:0]             r_line;

  logic                            w_phase_last;
  logic                            w_bit_last;
  logic                            w_accept;
  logic [INDEX_W-1:0]              w_sel;
  logic [CHANNELS-1:0]             w_line_next;

  assign w_phase_last = (r_phase == PHASE_LAST);
  assign w_bit_last   = (r_bit_idx == INDEX_LAST);
  assign ready        = (r_state == S_IDLE) || ((r_state == S_BIT) && w_phase_last && w_bit_last);
  assign w_accept     = enable && ready;
  assign w_sel        = MSB_FIRST ? (INDEX_LAST - r_bit_idx) : r_bit_idx;
  assign line         = r_line;

  // Line is registered from the current phase, so a word accepted at edge t rises at edge t+1.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [DATA_WIDTH-1:0] w_word;
      logic                  w_bit;
      assign w_word = r_word[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_bit  = w_word[w_sel];
      assign w_line_next[gi] = (r_state == S_BIT) && r_mask[gi] &&
                               (r_phase < (w_bit ? ONE_HIGH : ZERO_HIGH));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_LATCH;
      r_latch_cnt <= '0;
      r_phase     <= '0;
      r_bit_idx   <= '0;
      r_word      <= '0;
      r_mask      <= '0;
      r_line      <= '0;
    end else begin
      r_line <= w_line_next;
      case (r_state)
        S_LATCH: begin
          if (r_latch_cnt == LATCH_LAST) begin
            r_latch_cnt <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_latch_cnt <= r_latch_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_word    <= data;
            r_mask    <= channel_mask;
            r_bit_idx <= '0;
            r_phase   <= '0;
            r_state   <= S_BIT;
          end
        end
        S_BIT: begin
          if (w_phase_last) begin
            r_phase <= '0;
            if (w_bit_last) begin
              r_bit_idx <= '0;
              if (w_accept) begin
                r_word <= data;
                r_mask <= channel_mask;
              end else begin
                r_latch_cnt <= '0;
                r_state     <= S_LATCH;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        default: r_state <= S_LATCH;
      endcase
    end
  end
endmodule

// File: tb/tb_unipolar_rz_multi.sv
// Bench for unipolar_rz_multi: LSB-first and MSB-first instances, pulse-width scoreboard per line.
module tb_unipolar_rz_multi;
  localparam int CH       = 4;
  localparam int DW       = 24;
  localparam int PERIOD   = 120;
  localparam int ZERO_H   = 30;
  localparam int ONE_H    = 60;
  localparam int RESET_C  = 8000;
  localparam int WAIT_MAX = 12000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n = 1'b1;
  logic [CH*DW-1:0] data_a = '0, data_b = '0;
  logic [CH-1:0]    mask_a = '0, mask_b = '0;
  logic             en_a = 1'b0, en_b = 1'b0;
  logic             ready_a, ready_b;
  logic [CH-1:0]    line_a, line_b;
  logic [2*CH-1:0]  all_line;

  unipolar_rz_multi dut_a (
    .clock(clk), .reset_n(reset_n), .data(data_a), .channel_mask(mask_a),
    .enable(en_a), .ready(ready_a), .line(line_a)
  );

  unipolar_rz_multi #(.MSB_FIRST(1'b1)) dut_b (
    .clock(clk), .reset_n(reset_n), .data(data_b), .channel_mask(mask_b),
    .enable(en_b), .ready(ready_b), .line(line_b)
  );

  assign all_line = {line_b, line_a};

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_q[2*CH][$];
  int rise_q[2*CH][$];
  int hcnt[2*CH];
  int ones_cnt[2*CH];
  bit prev[2*CH];

  function automatic void check(string name, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Measures every high pulse and checks it against the expected width queued at acceptance.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 2*CH; k++) begin
        hcnt[k] = 0;
        prev[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2*CH; k++) begin
        if (all_line[k]) begin
          if (!prev[k]) rise_q[k].push_back(cyc);
          hcnt[k]++;
        end else if (prev[k]) begin
          if (exp_q[k].size() == 0) check($sformatf("unexpected_pulse line%0d", k), hcnt[k], 0);
          else check($sformatf("pulse_width line%0d", k), hcnt[k], exp_q[k].pop_front());
          if (hcnt[k] >= 45) ones_cnt[k]++;
          hcnt[k] = 0;
        end
        prev[k] = all_line[k];
      end
    end
  end

  task automatic push_expected(input logic [CH*DW-1:0] d, input logic [CH-1:0] m,
                               input bit use_b, input int nbits);
    logic [DW-1:0] w;
    bit b;
    for (int c = 0; c < CH; c++) begin
      if (m[c]) begin
        w = d[c*DW +: DW];
        for (int i = 0; i < nbits; i++) begin
          b = use_b ? w[DW-1-i] : w[i];
          exp_q[use_b ? CH + c : c].push_back(b ? ONE_H : ZERO_H);
        end
      end
    end
  endtask

  // Returns just after the acceptance edge, with data/mask already scrambled.
  task automatic send_word(input logic [CH*DW-1:0] d, input logic [CH-1:0] m,
                           input bit use_b, input int nbits, output int waited);
    if (use_b) begin data_b = d; mask_b = m; en_b = 1'b1; end
    else begin data_a = d; mask_a = m; en_a = 1'b1; end
    waited = 0;
    while (!(use_b ? ready_b : ready_a) && waited < WAIT_MAX) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= WAIT_MAX) check("ready_timeout", waited, 0);
    push_expected(d, m, use_b, nbits);
    $display("cycle %0d: dut_%s accepts data=%h mask=%b", cyc, use_b ? "b" : "a", d, m);
    @(posedge clk); #1;
    if (use_b) begin data_b = ~d; mask_b = ~m; end
    else begin data_a = ~d; mask_a = ~m; end
  endtask

  task automatic measure_latch(input bit use_b);
    int first_high = -1;
    int low_after = -1;
    int back = -1;
    logic r;
    for (int n = 1; n <= WAIT_MAX && back < 0; n++) begin
      @(posedge clk); #1;
      r = use_b ? ready_b : ready_a;
      if (first_high < 0) begin
        if (r) first_high = n;
      end else if (low_after < 0) begin
        if (!r) low_after = n;
      end else if (r) begin
        back = n;
      end
    end
    check("ready_in_final_cycle", first_high, PERIOD*DW - 1);
    check("ready_drop_after_word", low_after, PERIOD*DW);
    check("ready_after_latch", back, PERIOD*DW + RESET_C);
  endtask

  task automatic check_drained();
    int left = 0;
    for (int k = 0; k < 2*CH; k++) left += exp_q[k].size();
    check("scoreboard_left", left, 0);
  endtask

  typedef struct {
    logic [CH*DW-1:0] data;
    logic [CH-1:0]    mask;
    bit               use_b;
    int               exp_ones[CH];
  } row_t;

  row_t rows[3];

  initial begin
    int waited;
    int n;
    int bad;
    logic [CH*DW-1:0] d;

    rows[0].data = {24'h123456, 24'hffffff, 24'h000000, 24'habcdef};
    rows[0].mask = 4'hf; rows[0].use_b = 1'b0;
    rows[0].exp_ones = '{17, 0, 24, 9};
    rows[1].data = {24'h0f0f0f, 24'hffffff, 24'h000000, 24'h800001};
    rows[1].mask = 4'hf; rows[1].use_b = 1'b1;
    rows[1].exp_ones = '{2, 0, 24, 12};
    rows[2].data = {CH*DW{1'b1}};
    rows[2].mask = 4'b0101; rows[2].use_b = 1'b0;
    rows[2].exp_ones = '{24, 0, 24, 0};

    // Reset and latch after release
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_a", int'(ready_a), 0);
    check("reset_ready_b", int'(ready_b), 0);
    check("reset_lines", int'(all_line), 0);
    reset_n = 1'b1;
    n = 0;
    while (!ready_a && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
    check("ready_after_reset", n, RESET_C);
    check("ready_b_after_reset", int'(ready_b), 1);

    // Table of single words
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2*CH; k++) ones_cnt[k] = 0;
      send_word(rows[r].data, rows[r].mask, rows[r].use_b, DW, waited);
      en_a = 1'b0; en_b = 1'b0;
      measure_latch(rows[r].use_b);
      for (int c = 0; c < CH; c++)
        check($sformatf("ones_row%0d_ch%0d", r, c),
              ones_cnt[(rows[r].use_b ? CH : 0) + c], rows[r].exp_ones[c]);
      check_drained();
    end

    // Back-to-back stream of four words
    for (int k = 0; k < 2*CH; k++) rise_q[k].delete();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < CH; c++) d[c*DW +: DW] = 24'(c*24'h111111 + w);
      send_word(d, 4'hf, 1'b0, DW, waited);
      if (w > 0) check("stream_ready_gap", waited, PERIOD*DW - 1);
    end
    en_a = 1'b0;
    measure_latch(1'b0);
    for (int k = 0; k < CH; k++) begin
      check($sformatf("stream_rises ch%0d", k), rise_q[k].size(), 4*DW);
      bad = 0;
      for (int i = 0; i < rise_q[k].size(); i++) begin
        if (i > 0 && rise_q[k][i] - rise_q[k][i-1] != PERIOD) bad++;
        if (i >= rise_q[0].size() || rise_q[k][i] != rise_q[0][i]) bad++;
      end
      check($sformatf("stream_period_errors ch%0d", k), bad, 0);
    end
    check_drained();

    // Reset in the high phase of bit 10
    d = {24'h0f0f0f, 24'h00ffff, 24'h000000, 24'hffffff};
    send_word(d, 4'hf, 1'b0, 10, waited);
    en_a = 1'b0;
    repeat (10*PERIOD + 21) @(posedge clk);
    #1;
    check("line_before_reset", int'(line_a[0]), 1);
    reset_n = 1'b0;
    #1;
    check("line_in_reset", int'(line_a), 0);
    check("ready_in_reset", int'(ready_a), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    while (!ready_a && n < WAIT_MAX) begin @(posedge clk); #1; n++; end
    check("ready_after_midword_reset", n, RESET_C);
    check_drained();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
